// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// SERIAL_SUB_OVF_EN adds the ovf result bit.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock, valid/ready on both sides.
// SERIAL_SUB_OVF_EN adds a registered two's-complement overflow flag (ovf).
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ad_sr;     // minuend shifts out LSB-first while difference bits fill from the MSB
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             d_c;
    logic             br_nxt_c;
    logic             accept_c;
    logic             last_c;
    logic [WIDTH-1:0] ad_nxt_c;

    // Full-subtractor bit slice and control decodes
    always_comb begin
        d_c      = ad_sr[0] ^ b_sr[0] ^ br;
        br_nxt_c = (~ad_sr[0] & b_sr[0]) | (~ad_sr[0] & br) | (b_sr[0] & br);
        ad_nxt_c = {d_c, ad_sr[WIDTH-1:1]};
        accept_c = (state == IDLE) && bus.in_valid;
        last_c   = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_c)        state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_sr       <= '0;
            b_sr        <= '0;
            br          <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
        end else begin
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == HOLD);
            if (accept_c) begin
                ad_sr <= bus.a;
                b_sr  <= bus.b;
                br    <= bus.bin;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                ad_sr <= ad_nxt_c;
                b_sr  <= b_sr >> 1;
                br    <= br_nxt_c;
                cnt   <= cnt + CNT_W'(1);
                if (last_c) begin
                    diff_q <= ad_nxt_c;
                    bout_q <= br_nxt_c;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb, ovf_q;

    // Operand signs are captured at acceptance; the result sign is the last bit produced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept_c) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if (last_c) begin
            ovf_q <= (a_msb != b_msb) && (d_c != a_msb);
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(4)) bus ();
    serial_subtractor #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; returns result seen at out_valid and cycles from accepting edge
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         output logic [3:0] d, output logic bo, output int lat);
        int n = 0;
        while (!bus.in_ready && n < 50) begin tick(); n++; end
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin tick(); lat++; end
        d  = bus.diff;
        bo = bus.bout;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b1;
        #12;
        n_vec++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.diff !== 4'd0)      begin n_err++; $display("FAIL reset_diff: got %0d want 0", bus.diff); end
        n_vec++; if (bus.bout !== 1'b0)      begin n_err++; $display("FAIL reset_bout: got %b want 0", bus.bout); end
`ifdef SERIAL_SUB_OVF_EN
        n_vec++; if (bus.ovf !== 1'b0)       begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic [3:0] d; logic bo; int lat;
        bus.out_ready = 1'b1;
        do_op(4'd9, 4'd3, 1'b0, d, bo, lat);
        n_vec++; if (lat !== 4)    begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_vec++; if (d !== 4'd6)   begin n_err++; $display("FAIL basic_diff: got %0d want 6", d); end
        n_vec++; if (bo !== 1'b0)  begin n_err++; $display("FAIL basic_bout: got %b want 0", bo); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b want 0", bus.in_ready); end
        tick();
        n_vec++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL basic_idle_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.diff !== 4'd6)      begin n_err++; $display("FAIL basic_diff_kept: got %0d want 6", bus.diff); end
    endtask

    task automatic test_wrap;
        logic [3:0] ta [3] = '{4'd3, 4'd0, 4'd15};
        logic [3:0] tb [3] = '{4'd5, 4'd0, 4'd15};
        logic       tc [3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] td [3] = '{4'd14, 4'd15, 4'd15};
        logic [3:0] d; logic bo; int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], tc[i], d, bo, lat);
            n_vec++; if (d !== td[i]) begin n_err++; $display("FAIL wrap_diff[%0d]: got %0d want %0d", i, d, td[i]); end
            n_vec++; if (bo !== 1'b1) begin n_err++; $display("FAIL wrap_bout[%0d]: got %b want 1", i, bo); end
            tick();
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] d; logic bo; int lat;
        bus.out_ready = 1'b0;
        do_op(4'd12, 4'd4, 1'b0, d, bo, lat);
        n_vec++; if (d !== 4'd8)  begin n_err++; $display("FAIL bp_diff: got %0d want 8", d); end
        n_vec++; if (bo !== 1'b0) begin n_err++; $display("FAIL bp_bout: got %b want 0", bo); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.a = 4'd1; bus.b = 4'd2; bus.bin = 1'b1;
            tick();
            n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus.out_valid); end
            n_vec++; if (bus.diff !== 4'd8)      begin n_err++; $display("FAIL bp_hold_diff[%0d]: got %0d want 8", i, bus.diff); end
            n_vec++; if (bus.in_ready !== 1'b0)  begin n_err++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        tick();
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_phantom: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.diff !== 4'd8)      begin n_err++; $display("FAIL bp_diff_kept: got %0d want 8", bus.diff); end
    endtask

    task automatic test_reset_midop;
        logic [3:0] d; logic bo; int lat;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.a = 4'd10; bus.b = 4'd1; bus.bin = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.diff !== 4'd0)      begin n_err++; $display("FAIL midrst_diff: got %0d want 0", bus.diff); end
        n_vec++; if (bus.bout !== 1'b0)      begin n_err++; $display("FAIL midrst_bout: got %b want 0", bus.bout); end
        #20 rst_n = 1'b1;
        tick();
        do_op(4'd5, 4'd2, 1'b0, d, bo, lat);
        n_vec++; if (lat !== 4)   begin n_err++; $display("FAIL midrst_latency: got %0d want 4", lat); end
        n_vec++; if (d !== 4'd3)  begin n_err++; $display("FAIL midrst_diff_after: got %0d want 3", d); end
        n_vec++; if (bo !== 1'b0) begin n_err++; $display("FAIL midrst_bout_after: got %b want 0", bo); end
        tick();
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf;
        logic [3:0] ta [3] = '{4'd7, 4'd8, 4'd6};
        logic [3:0] tb [3] = '{4'd15, 4'd1, 4'd2};
        logic [3:0] td [3] = '{4'd8, 4'd7, 4'd4};
        logic       tbo[3] = '{1'b1, 1'b0, 1'b0};
        logic       tov[3] = '{1'b1, 1'b1, 1'b0};
        logic [3:0] d; logic bo; int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], 1'b0, d, bo, lat);
            n_vec++; if (d !== td[i])          begin n_err++; $display("FAIL ovf_diff[%0d]: got %0d want %0d", i, d, td[i]); end
            n_vec++; if (bo !== tbo[i])        begin n_err++; $display("FAIL ovf_bout[%0d]: got %b want %b", i, bo, tbo[i]); end
            n_vec++; if (bus.ovf !== tov[i])   begin n_err++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, bus.ovf, tov[i]); end
            tick();
        end
    endtask
`endif

    task automatic test_random;
        logic [3:0] a, b, d; logic bin, bo; int lat;
        logic [4:0] exp;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            bin = 1'($urandom_range(0, 1));
            exp = {1'b0, a} - {1'b0, b} - {4'd0, bin};
            do_op(a, b, bin, d, bo, lat);
            n_vec++; if ({bo, d} !== exp) begin n_err++; $display("FAIL rand[%0d] %0d-%0d-%0d: got %0d want %0d", i, a, b, bin, {bo, d}, exp); end
            n_vec++; if (lat !== 4)       begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want 4", i, lat); end
`ifdef SERIAL_SUB_OVF_EN
            n_vec++; if (bus.ovf !== ((a[3] != b[3]) && (exp[3] != a[3])))
                begin n_err++; $display("FAIL rand_ovf[%0d]: got %b", i, bus.ovf); end
`endif
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_midop();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
